prio_arbiter_rr: RTL

- Parametrised N-requester arbiter with registered grant outputs. It is the clocked successor of the 8:3 priority encoder.
- Two arbitration modes:
  - Fixed priority: the highest index wins, as in the encoder.
  - Rotating round-robin.
- Each grant is held until acknowledged, withdrawn, or timed out.
- Sits between N request sources and one shared resource, such as a bus master port or a shared FIFO write side.

---
 rtl/prio_arbiter_rr.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/prio_arbiter_rr.sv
// -----------------------------------------------------------------------------
// prio_arbiter_rr
// N-requester arbiter with registered grant outputs. Clocked successor of the
// 8:3 priority encoder: in fixed mode the highest requesting index wins, in
// round-robin mode the search rotates so the last released holder has the
// lowest priority. A grant is held until acknowledged, withdrawn by its
// requester, or revoked after MAX_HOLD cycles.
//
// Ports
//   clk         rising-edge clock
//   rst_n       asynchronous active-low reset (release is expected to be
//               synchronised to clk upstream)
//   req[N]      request vector, bit i = requester i wants the resource
//   ack         current holder is done (only looked at while gnt_valid=1)
//   gnt_valid   a grant is active
//   gnt_idx     binary index of the granted requester
//   gnt_onehot  one-hot grant vector, all zero while gnt_valid=0
//   timeout     one-cycle pulse: the previous grant was revoked by MAX_HOLD
//
// State table
//   state    | meaning
//   ---------+---------------------------------------------------------------
//   ST_IDLE  | no grant active; any winner is granted on the next edge
//   ST_GRANT | grant active; watch ack / hold limit / withdrawal for release
// -----------------------------------------------------------------------------
module prio_arbiter_rr #(
   parameter int N        = 8,
   parameter int RR_MODE  = 1,
   parameter int MAX_HOLD = 0
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [N-1:0]         req,
   input  logic                 ack,
   output logic                 gnt_valid,
   output logic [$clog2(N)-1:0] gnt_idx,
   output logic [N-1:0]         gnt_onehot,
   output logic                 timeout
);

   // Derived widths are local so they cannot drift from N / MAX_HOLD.
   localparam int IDXW = $clog2(N);
   localparam int CNTW = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_GRANT = 1'b1
   } state_t;

   state_t          state_q, state_d;
   logic [IDXW-1:0] ptr_q, ptr_d;
   logic [CNTW-1:0] cnt_q, cnt_d;

   logic            valid_d;
   logic [IDXW-1:0] idx_d;
   logic [N-1:0]    onehot_d;
   logic            timeout_d;

   logic            hold_expired;
   logic            rel_ack;
   logic            rel_to;
   logic            rel_abort;
   logic [IDXW-1:0] rot;
   logic [IDXW:0]   pick;
   logic            win_found;
   logic [IDXW-1:0] win_idx;

   // Descending search starting at (rot-1) mod N, wrapping, so index rot is
   // checked last. rot=0 starts at N-1, which is exactly fixed priority.
   // Result is {found, index}.
   function automatic logic [IDXW:0] search(input logic [N-1:0]    r,
                                            input logic [IDXW-1:0] rot_pt);
      logic [IDXW:0]   res;
      logic [IDXW-1:0] jj;
      int              j;
      res = '0;
      for (int k = 0; k < N; k++) begin
         j = int'(rot_pt) - 1 - k;
         if (j < 0) begin
            j = j + N;
         end
         jj = IDXW'(j);
         if (!res[IDXW] && r[jj]) begin
            res = {1'b1, jj};
         end
      end
      return res;
   endfunction

   assign hold_expired = (MAX_HOLD != 0) && (cnt_q == CNTW'(MAX_HOLD));

   // Release decode in priority order: ack, then hold limit, then withdrawal.
   always_comb begin
      rel_ack   = 1'b0;
      rel_to    = 1'b0;
      rel_abort = 1'b0;
      if (state_q == ST_GRANT) begin
         rel_ack   = ack;
         rel_to    = !ack && hold_expired;
         rel_abort = !ack && !hold_expired && !req[gnt_idx];
      end
   end

   // The pointer update on ack/timeout must already steer this cycle's search,
   // so the rotation point is taken from gnt_idx directly in that case.
   always_comb begin
      rot = ptr_q;
      if (rel_ack || rel_to) begin
         rot = gnt_idx;
      end
      if (RR_MODE == 0) begin
         rot = '0;
      end
   end

   assign pick      = search(req, rot);
   assign win_found = pick[IDXW];
   assign win_idx   = pick[IDXW-1:0];

   always_comb begin
      state_d   = state_q;
      ptr_d     = ptr_q;
      cnt_d     = cnt_q;
      valid_d   = gnt_valid;
      idx_d     = gnt_idx;
      onehot_d  = gnt_onehot;
      timeout_d = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            if (win_found) begin
               state_d           = ST_GRANT;
               valid_d           = 1'b1;
               idx_d             = win_idx;
               onehot_d          = '0;
               onehot_d[win_idx] = 1'b1;
               cnt_d             = CNTW'(1);
            end
         end

         ST_GRANT: begin
            if (rel_ack || rel_to) begin
               ptr_d = gnt_idx;
            end
            timeout_d = rel_to;

            if (rel_ack || rel_to || rel_abort) begin
               if (win_found) begin
                  // back-to-back handover, no bubble
                  valid_d           = 1'b1;
                  idx_d             = win_idx;
                  onehot_d          = '0;
                  onehot_d[win_idx] = 1'b1;
                  cnt_d             = CNTW'(1);
               end else begin
                  // gnt_idx deliberately keeps its last value
                  state_d  = ST_IDLE;
                  valid_d  = 1'b0;
                  onehot_d = '0;
                  cnt_d    = '0;
               end
            end else if ((MAX_HOLD != 0) && (cnt_q != CNTW'(MAX_HOLD))) begin
               cnt_d = cnt_q + CNTW'(1);
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         ptr_q      <= '0;
         cnt_q      <= '0;
         gnt_valid  <= 1'b0;
         gnt_idx    <= '0;
         gnt_onehot <= '0;
         timeout    <= 1'b0;
      end else begin
         state_q    <= state_d;
         ptr_q      <= ptr_d;
         cnt_q      <= cnt_d;
         gnt_valid  <= valid_d;
         gnt_idx    <= idx_d;
         gnt_onehot <= onehot_d;
         timeout    <= timeout_d;
      end
   end

`ifndef SYNTHESIS
   a_onehot_match: assert property (@(posedge clk) disable iff (!rst_n)
      gnt_valid |-> (gnt_onehot == (N'(1) << gnt_idx)));

   a_onehot_idle: assert property (@(posedge clk) disable iff (!rst_n)
      !gnt_valid |-> (gnt_onehot == '0));

   a_state_valid: assert property (@(posedge clk) disable iff (!rst_n)
      (state_q == ST_GRANT) == gnt_valid);
`endif

endmodule
